// File: rtl/minimig_bus_pkg.sv
// Shared state encoding and defaults for the minimig 68000 bus initiator.
package minimig_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    S0,
    S1,
    S2,
    S3,
    S4,
    S5,
    S6,
    S7
  } bus_state_t;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/minimig_bus_timeout.sv
// Wait-state counter for the bus initiator; saturates at TIMEOUT and flags expiry.
module minimig_bus_timeout
  import minimig_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != LIMIT) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/minimig_m68k_bus_initiator.sv
// 68000-style bus initiator: turns a req/ack handshake into an S0..S7 bus cycle
// paced by the 7 MHz phase enables, with DTACK wait states and a bus-error timeout.
module minimig_m68k_bus_initiator
  import minimig_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        clk7n_en,
  input  logic        req,
  input  logic        we,
  input  logic [23:1] adr,
  input  logic [1:0]  bs,
  input  logic [15:0] wdat,
  output logic [15:0] rdat,
  output logic        ack,
  output logic        err,
  output logic        _as,
  output logic        _uds,
  output logic        _lds,
  output logic        r_w,
  output logic [23:1] address,
  output logic [15:0] cpudata,
  input  logic [15:0] data,
  input  logic        _dtack
);

  bus_state_t  state, state_next;
  logic        we_l;
  logic [1:0]  bs_l;
  logic [23:1] adr_l;
  logic [15:0] wdat_l;
  logic        err_flag;
  logic        expired;
  logic        wait_inc;
  logic        start;
  logic        finish;
  logic        as_on;
  logic        ds_on;

  minimig_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (start),
    .inc     (wait_inc),
    .expired (expired)
  );

  always_comb begin
    state_next = state;
    wait_inc   = 1'b0;
    case (state)
      IDLE: if (clk7_en && req && _dtack) state_next = S0;
      S0:   if (clk7n_en) state_next = S1;
      S1:   if (clk7_en) state_next = S2;
      S2:   if (clk7n_en) state_next = S3;
      S3:   if (clk7_en) state_next = S4;
      S4: begin
        // DTACK wins over a coincident timeout so a late responder still completes.
        if (clk7n_en) begin
          if (!_dtack)      state_next = S5;
          else if (expired) state_next = S7;
          else              wait_inc = 1'b1;
        end
      end
      S5:   if (clk7_en) state_next = S6;
      S6:   if (clk7n_en) state_next = S7;
      S7:   if (clk7_en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign start  = (state == IDLE) && (state_next == S0);
  assign finish = (state == S7) && (state_next == IDLE);
  assign as_on  = state_next inside {S2, S3, S4, S5, S6, S7};
  // Writes hold the data strobes off until the data has had a phase to settle.
  assign ds_on  = we_l ? (state_next inside {S4, S5, S6, S7}) : as_on;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      we_l     <= 1'b0;
      bs_l     <= 2'b00;
      adr_l    <= '0;
      wdat_l   <= '0;
      err_flag <= 1'b0;
      _as      <= 1'b1;
      _uds     <= 1'b1;
      _lds     <= 1'b1;
      r_w      <= 1'b1;
      address  <= '0;
      cpudata  <= '0;
      rdat     <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        we_l     <= we;
        bs_l     <= bs;
        adr_l    <= adr;
        wdat_l   <= wdat;
        err_flag <= 1'b0;
      end
      if (state == S4 && state_next == S7) err_flag <= 1'b1;
      _as  <= !as_on;
      _uds <= !(ds_on && bs_l[1]);
      _lds <= !(ds_on && bs_l[0]);
      r_w  <= !(as_on && we_l);
      if (state == S0 && state_next == S1) address <= adr_l;
      if (state == S2 && state_next == S3 && we_l) cpudata <= wdat_l;
      if (state == S6 && state_next == S7 && !we_l) rdat <= data;
      ack <= finish && !err_flag;
      err <= finish && err_flag;
    end
  end

endmodule

// File: doc/minimig_m68k_bus_initiator.md
MINIMIG_M68K_BUS_INITIATOR -- requirements
Module: minimig_m68k_bus_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: the maximum number of clk7n_en samples spent in S4 before a bus error is raised.
REQ-002 SHALL have port clk, input, 1: 28 MHz system clock.
REQ-003 SHALL have port reset, input, 1: asynchronous reset, active-high.
REQ-004 SHALL have port clk7_en, input, 1: CPU-clock rising-phase enable.
REQ-005 SHALL have port clk7n_en, input, 1: CPU-clock falling-phase enable.
REQ-006 SHALL have port req, input, 1: request, held until ack or err.
REQ-007 SHALL have port we, input, 1: 1 = write.
REQ-008 SHALL have port adr, input, 23 bits [23:1]: request address.
REQ-009 SHALL have port bs, input, 2: byte selects, [1] = upper, [0] = lower.
REQ-010 SHALL have port wdat, input, 16: write data.
REQ-011 SHALL have port rdat, output, 16: read data, registered.
REQ-012 SHALL have port ack, output, 1: one-clk completion pulse.
REQ-013 SHALL have port err, output, 1: one-clk timeout pulse.
REQ-014 SHALL have port _as, output, 1: address strobe, active-low.
REQ-015 SHALL have port _uds, output, 1: upper data strobe, active-low.
REQ-016 SHALL have port _lds, output, 1: lower data strobe, active-low.
REQ-017 SHALL have port r_w, output, 1: 1 = read.
REQ-018 SHALL have port address, output, 23 bits [23:1]: bus address.
REQ-019 SHALL have port cpudata, output, 16: write data toward the bridge.
REQ-020 SHALL have port data, input, 16: read data from the bridge.
REQ-021 SHALL have port _dtack, input, 1: data acknowledge, active-low.

Function
REQ-022 All state SHALL advance only on clk edges qualified by clk7_en or clk7n_en.
REQ-023 States SHALL be IDLE, S0..S7; even states are entered on clk7_en and odd states on clk7n_en, except where REQ-029 says otherwise.
REQ-024 IDLE->S0 SHALL occur on clk7_en only when req=1 and _dtack=1; a stale low _dtack holds IDLE.
REQ-025 In S0 the block SHALL latch adr, we, bs and wdat; request inputs are ignored until ack or err.
REQ-026 S0->S1: address SHALL be driven from the latched adr and held until IDLE.
REQ-027 S1->S2: _as SHALL go low; reads assert the selected _uds/_lds; writes drive r_w=0.
REQ-028 S2->S3: writes SHALL drive cpudata from latched wdat, held to IDLE; S3->S4: writes assert the selected _uds/_lds.
REQ-029 In S4, on each clk7n_en: _dtack=0 -> S5; else stay in S4 (wait state) and increment the wait counter.
REQ-030 When the wait counter reaches TIMEOUT, the block SHALL go S4->S7 with an error flag set.
REQ-031 S5->S6 on clk7_en; S6->S7 on clk7n_en; reads latch data into rdat at S6->S7.
REQ-032 S7->IDLE on clk7_en: _as/_uds/_lds SHALL go to 1, r_w to 1, and ack=1 (or err=1 if timed out) for exactly one clk.
REQ-033 ack and err SHALL be mutually exclusive; rdat SHALL be unchanged on err or write.
REQ-034 bs=00 SHALL still run a full cycle with no data strobes asserted.
REQ-035 Minimum cycle, req to ack, SHALL be 4 clk7 periods (16 clk) with zero wait states.
REQ-036 The wait counter SHALL be width clog2(TIMEOUT+1) and clear on S0 entry.
REQ-037 Back-to-back: req held high after ack SHALL start the next S0 no earlier than the next clk7_en.

Reset
REQ-038 reset=1 SHALL force IDLE asynchronously, including mid-cycle.
REQ-039 During reset: _as=_uds=_lds=1, r_w=1, address=0, cpudata=0, rdat=0, ack=0, err=0, wait counter=0.
REQ-040 A cycle aborted by reset SHALL produce neither ack nor err.

Structure
REQ-041 The state enum typedef and the TIMEOUT default SHALL live in shared package minimig_bus_pkg.
REQ-042 The wait counter SHALL be a sub-module minimig_bus_timeout (inputs clr, inc; output expired).
REQ-043 All outputs SHALL be registered.

Verification
REQ-044 Zero-wait read: adr=0xBFE001, bs=01, responder _dtack low when S4 is reached, data=0x00A5 -> rdat=0x00A5, ack 16 clk after req, _uds never low.
REQ-045 Write with 3 wait states: wdat=0x1234, bs=11 -> data strobes low from S4 entry, cpudata=0x1234 stable while _as low, ack 28 clk after req.
REQ-046 Timeout: TIMEOUT=4, _dtack held high -> err pulse after 4 S4 waits, no ack, rdat unchanged.
REQ-047 Stale _dtack: _dtack low when req rises -> _as stays high until _dtack=1, then the cycle proceeds normally.
REQ-048 Reset asserted in S4 -> strobes high in the same clk, IDLE, no ack/err; the next req completes normally.
REQ-049 Back-to-back: two reads with req held -> _as high for at least one clk7 phase between cycles, two ack pulses.
